// File: rtl/lcd_rgb_timing_gen.sv
// lcd_rgb_timing_gen: panel raster timing that drains a byte FIFO into RGB565 byte pairs
module lcd_rgb_timing_gen #(
  parameter int H_ACTIVE = 1600,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 20,
  parameter int H_BP     = 46,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 13,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 23
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic       FIFO_Empty,
  input  logic [7:0] FIFO_Data,
  output logic       FIFO_Re,
  output logic       HSYNC,
  output logic       VSYNC,
  output logic       DE,
  output logic [7:0] RGB_Out,
  output logic       Byte_Phase,
  output logic       Underflow,
  output logic       Frame_Done
);
  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int H_ON = H_SYNC + H_BP;
  localparam int V_ON = V_SYNC + V_BP;
  localparam logic PH0 = 1'(H_ON % 2);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic en_frame_q, en_frame_d;
  logic act1_q, act1_d, hsync1_q, hsync1_d, vsync1_q, vsync1_d, phase1_q, phase1_d, miss1_q, miss1_d;
  logic hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d, phase_q, phase_d;
  logic [7:0] rgb_q, rgb_d;
  logic underflow_q, underflow_d, frame_done_q, frame_done_d;
  logic signed [31:0] hi, vi;
  logic start_c, h_last_c, v_last_c, hsync_c, vsync_c, act_c, phase_c, miss_c;

  // Decode the raster position into sync, active-window and frame-boundary terms
  always_comb begin
    hi = 32'(h_q);
    vi = 32'(v_q);
    start_c = (h_q == '0) && (v_q == '0);
    h_last_c = hi == H_TOTAL - 1;
    v_last_c = vi == V_TOTAL - 1;
    hsync_c = hi < H_SYNC;
    vsync_c = vi < V_SYNC;
    act_c = hi >= H_ON && hi < H_ON + H_ACTIVE && vi >= V_ON && vi < V_ON + V_ACTIVE && en_frame_q;
    phase_c = h_q[0] ^ PH0;
    miss_c = act_c && FIFO_Empty;
    FIFO_Re = act_c && !FIFO_Empty;
  end

  // Next state: counters, frame-start enable capture and the two-stage output pipeline
  always_comb begin
    h_d = h_last_c ? '0 : h_q + HW'(1);
    v_d = h_last_c ? (v_last_c ? '0 : v_q + VW'(1)) : v_q;
    en_frame_d = start_c ? EN : en_frame_q;
    act1_d = act_c;
    hsync1_d = hsync_c;
    vsync1_d = vsync_c;
    phase1_d = phase_c;
    miss1_d = miss_c;
    hsync_d = hsync1_q;
    vsync_d = vsync1_q;
    phase_d = phase1_q;
    de_d = act1_q;
    rgb_d = (act1_q && !miss1_q) ? FIFO_Data : 8'h00;
    underflow_d = miss_c ? 1'b1 : start_c ? 1'b0 : underflow_q;
    frame_done_d = h_last_c && v_last_c;
  end

  // State registers; reset aborts the raster at once
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      h_q <= '0;
      v_q <= '0;
      en_frame_q <= 1'b0;
      act1_q <= 1'b0;
      hsync1_q <= 1'b0;
      vsync1_q <= 1'b0;
      phase1_q <= 1'b0;
      miss1_q <= 1'b0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      phase_q <= 1'b0;
      de_q <= 1'b0;
      rgb_q <= 8'h00;
      underflow_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
      en_frame_q <= en_frame_d;
      act1_q <= act1_d;
      hsync1_q <= hsync1_d;
      vsync1_q <= vsync1_d;
      phase1_q <= phase1_d;
      miss1_q <= miss1_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      phase_q <= phase_d;
      de_q <= de_d;
      rgb_q <= rgb_d;
      underflow_q <= underflow_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign HSYNC = hsync_q;
  assign VSYNC = vsync_q;
  assign DE = de_q;
  assign RGB_Out = rgb_q;
  assign Byte_Phase = phase_q;
  assign Underflow = underflow_q;
  assign Frame_Done = frame_done_q;
endmodule

// File: tb/tb_lcd_rgb_timing_gen.sv
// tb_lcd_rgb_timing_gen: scoreboard bench for the raster generator on a 14x7 tiny panel
`timescale 1ns/1ps
module tb_lcd_rgb_timing_gen;
  logic CLK = 1'b0, RST = 1'b1, EN = 1'b1, FIFO_Empty = 1'b0, e5 = 1'b0;
  logic [7:0] FIFO_Data, RGB_Out, rgb5, fcnt;
  logic FIFO_Re, HSYNC, VSYNC, DE, Byte_Phase, Underflow, Frame_Done;
  logic re5, hs5, vs5, de5, ph5, uf5, fd5;
  int total = 0, bad = 0, s = 0, epoch = 1, uf_lo = 133, uf_hi = 196, nre = 0;
  logic [7:0] fen = 8'h37;
  logic [8:0] sb[$];
  int re_tab[5] = '{32, 31, 32, 0, 32};

  lcd_rgb_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                       .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .FIFO_Empty(FIFO_Empty), .FIFO_Data(FIFO_Data),
    .FIFO_Re(FIFO_Re), .HSYNC(HSYNC), .VSYNC(VSYNC), .DE(DE), .RGB_Out(RGB_Out),
    .Byte_Phase(Byte_Phase), .Underflow(Underflow), .Frame_Done(Frame_Done));

  lcd_rgb_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(0), .H_BP(0),
                       .V_ACTIVE(4), .V_FP(1), .V_SYNC(0), .V_BP(0)) dut5 (
    .CLK(CLK), .RST(RST), .EN(1'b1), .FIFO_Empty(e5), .FIFO_Data(8'h5A),
    .FIFO_Re(re5), .HSYNC(hs5), .VSYNC(vs5), .DE(de5), .RGB_Out(rgb5),
    .Byte_Phase(ph5), .Underflow(uf5), .Frame_Done(fd5));

  always #5 CLK = ~CLK;

  // FIFO model: data appears the cycle after a read strobe, counting up from 0 after reset
  always @(posedge CLK or posedge RST)
    if (RST) begin
      fcnt <= 8'd0;
      FIFO_Data <= 8'd0;
    end else if (FIFO_Re) begin
      FIFO_Data <= fcnt;
      fcnt <= fcnt + 8'd1;
    end

  // Cycles since reset release; equals the raster position index
  always @(posedge CLK or posedge RST) s <= RST ? 0 : s + 1;

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s s=%0d got=%0d want=%0d", nm, s, act, exp);
    end
  endtask

  task automatic push_frame(int base, int miss);
    for (int i = 0; i < 32; i++)
      sb.push_back({1'(i % 2), (i == miss) ? 8'h00 : 8'(base + i - ((miss >= 0 && i > miss) ? 1 : 0))});
  endtask

  task automatic go(int n);
    while (s < n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  // Monitor: timing checks every cycle, scoreboard pop whenever DE presents a byte
  always @(negedge CLK) begin
    int o, hp, vl, fr, hs, vs, fs;
    logic de_e;
    logic [8:0] e;
    o = s - 2;
    hp = o % 14;
    vl = (o / 14) % 7;
    fr = o / 98;
    hs = s % 14;
    vs = (s / 14) % 7;
    fs = s / 98;
    de_e = o >= 0 && hp >= 4 && hp < 12 && vl >= 2 && vl < 6 && fr < 8 && fen[fr];
    chk("hsync", HSYNC, o >= 0 && hp < 2);
    chk("vsync", VSYNC, o >= 0 && vl < 1);
    chk("de", DE, de_e);
    chk("fifo_re", FIFO_Re, hs >= 4 && hs < 12 && vs >= 2 && vs < 6 && fs < 8 && fen[fs] && !FIFO_Empty);
    chk("frame_done", Frame_Done, s > 0 && s % 98 == 0);
    chk("underflow", Underflow, s >= uf_lo && s <= uf_hi);
    if (DE) begin
      chk("sb_nonempty", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rgb", RGB_Out, e[7:0]);
        chk("phase", Byte_Phase, e[8]);
      end
    end else chk("rgb_idle", RGB_Out, 0);
    if (s == 0) nre = 0;
    else if (s % 98 == 0 && s / 98 <= 5) begin
      chk("reads_per_frame", nre, re_tab[s / 98 - 1]);
      nre = 0;
    end
    if (FIFO_Re) nre++;
    if (epoch == 1 && (s == 49 || s == 51 || s == 100 || s == 101))
      chk("underflow_set_wins", uf5, s == 51 || s == 100);
  end

  initial begin
    push_frame(0, -1);
    push_frame(32, 2);
    push_frame(63, -1);
    push_frame(95, -1);
    sb.push_back({1'b0, 8'd127});
    repeat (3) @(posedge CLK);
    #2;
    chk("rst_de", DE, 0);
    chk("rst_re", FIFO_Re, 0);
    RST = 1'b0;
    go(50);
    e5 = 1'b1;
    go(51);
    e5 = 1'b0;
    go(132);
    FIFO_Empty = 1'b1;
    go(133);
    FIFO_Empty = 1'b0;
    go(220);
    EN = 1'b0;
    go(330);
    EN = 1'b1;
    go(525);
    RST = 1'b1;
    epoch = 2;
    #1;
    chk("async_rst_de", DE, 0);
    chk("async_rst_rgb", RGB_Out, 0);
    chk("sb_flushed", sb.size(), 0);
    uf_lo = 1000;
    uf_hi = -1;
    fen = 8'h01;
    push_frame(0, -1);
    repeat (2) @(posedge CLK);
    #2;
    RST = 1'b0;
    go(120);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
